// File: rtl/matmul_pkg.sv
// ============================================================================
//  Module : matmul_pkg
//  Brief  : Shared defaults and state encodings for the matrix datapath.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package matmul_pkg;

    localparam int c_n_elem_default = 9;
    localparam int c_elem_w_default = 16;

    typedef enum logic [2:0] {
        SER_IDLE      = 3'd0,
        SER_ISSUE     = 3'd1,
        SER_WAIT_ACK  = 3'd2,
        SER_WAIT_DONE = 3'd3,
        SER_DONE      = 3'd4
    } ser_state_t;

    typedef enum logic [1:0] {
        CU_IDLE = 2'd0,
        CU_LOAD = 2'd1,
        CU_MULT = 2'd2,
        CU_SEND = 2'd3
    } cu_state_t;

endpackage

`default_nettype wire

// File: rtl/result_serializer_byte_select.sv
// ============================================================================
//  Module : result_serializer_byte_select
//  Brief  : Maps a frame byte index onto one byte of the captured result.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module result_serializer_byte_select
    import matmul_pkg::*;
#(
    parameter int N_ELEM    = c_n_elem_default,
    parameter int ELEM_W    = c_elem_w_default,
    parameter int MSB_FIRST = 1,
    parameter int IDX_W     = 5
) (
    input  logic [N_ELEM*ELEM_W-1:0] i_shadow,
    input  logic [IDX_W-1:0]         i_byte_idx,
    output logic [7:0]               o_byte
);

    localparam int c_bpe    = ELEM_W / 8;
    localparam int c_nbytes = N_ELEM * c_bpe;

    logic [7:0] w_lane [c_nbytes];

    // Each lane is a fixed slice, so the mux below only ever selects wires.
    for (genvar gi = 0; gi < c_nbytes; gi++) begin : g_lane
        localparam int c_k   = gi % c_bpe;
        localparam int c_src = (MSB_FIRST != 0) ? (gi - c_k + (c_bpe - 1 - c_k)) : gi;
        assign w_lane[gi] = i_shadow[8*c_src +: 8];
    end

    always_comb begin
        o_byte = 8'h00;
        if (int'(i_byte_idx) < c_nbytes) begin
            o_byte = w_lane[i_byte_idx];
        end
    end

endmodule

`default_nettype wire

// File: rtl/result_serializer.sv
// ============================================================================
//  Module : result_serializer
//  Brief  : Captures the product vector and streams it byte-wise to uart_tx.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module result_serializer
    import matmul_pkg::*;
#(
    parameter int N_ELEM      = c_n_elem_default,
    parameter int ELEM_W      = c_elem_w_default,
    parameter int MSB_FIRST   = 1,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [N_ELEM*ELEM_W-1:0] result,
    input  logic                     tx_busy,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    output logic                     busy,
    output logic                     done
);

    localparam int c_nbytes = N_ELEM * ELEM_W / 8;
    localparam int c_idx_w  = $clog2(c_nbytes + 1);
    localparam int c_tmr_w  = $clog2(ACK_TIMEOUT);

    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(c_nbytes - 1);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(ACK_TIMEOUT - 1);

    ser_state_t                 r_state;
    logic [N_ELEM*ELEM_W-1:0]   r_shadow;
    logic [c_idx_w-1:0]         r_byte_idx;
    logic [c_tmr_w-1:0]         r_timer;
    logic                       r_tx_start;
    logic [7:0]                 r_tx_data;
    logic                       r_busy;
    logic                       r_done;
    logic [7:0]                 w_byte;

    result_serializer_byte_select #(
        .N_ELEM    (N_ELEM),
        .ELEM_W    (ELEM_W),
        .MSB_FIRST (MSB_FIRST),
        .IDX_W     (c_idx_w)
    ) u_byte_select (
        .i_shadow   (r_shadow),
        .i_byte_idx (r_byte_idx),
        .o_byte     (w_byte)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= SER_IDLE;
            r_shadow   <= '0;
            r_byte_idx <= '0;
            r_timer    <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                SER_IDLE: begin
                    if (load) begin
                        r_shadow   <= result;
                        r_byte_idx <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= SER_ISSUE;
                    end
                end
                // A transmitter that is still busy holds us here without a pulse.
                SER_ISSUE: begin
                    if (!tx_busy) begin
                        r_tx_data  <= w_byte;
                        r_tx_start <= 1'b1;
                        r_timer    <= '0;
                        r_state    <= SER_WAIT_ACK;
                    end
                end
                SER_WAIT_ACK: begin
                    if (tx_busy) begin
                        r_state <= SER_WAIT_DONE;
                    end else if (r_timer == c_tmr_last) begin
                        r_state <= SER_ISSUE;
                    end else begin
                        r_timer <= r_timer + c_tmr_w'(1);
                    end
                end
                SER_WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_byte_idx <= r_byte_idx + c_idx_w'(1);
                        if (r_byte_idx == c_idx_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= SER_DONE;
                        end else begin
                            r_state <= SER_ISSUE;
                        end
                    end
                end
                SER_DONE: begin
                    r_state <= SER_IDLE;
                end
                default: begin
                    r_state <= SER_IDLE;
                end
            endcase
        end
    end

    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_result_serializer.sv
// ============================================================================
//  Module : tb_result_serializer
//  Brief  : Self-checking bench; MSB-first and LSB-first instances side by side.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_result_serializer;

    localparam int N_ELEM      = 9;
    localparam int ELEM_W      = 16;
    localparam int BPE         = ELEM_W / 8;
    localparam int NBYTES      = N_ELEM * BPE;
    localparam int ACK_TIMEOUT = 15;
    localparam int W           = N_ELEM * ELEM_W;
    localparam int NI          = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [W-1:0] result;
    logic         tx_busy_v  [NI];
    logic         tx_start_v [NI];
    logic [7:0]   tx_data_v  [NI];
    logic         busy_v     [NI];
    logic         done_v     [NI];

    always #5 clk = ~clk;

    // Instance 0 sends high byte first, instance 1 low byte first.
    for (genvar g = 0; g < NI; g++) begin : g_dut
        result_serializer #(
            .N_ELEM      (N_ELEM),
            .ELEM_W      (ELEM_W),
            .MSB_FIRST   ((g == 0) ? 1 : 0),
            .ACK_TIMEOUT (ACK_TIMEOUT)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .load     (load),
            .result   (result),
            .tx_busy  (tx_busy_v[g]),
            .tx_start (tx_start_v[g]),
            .tx_data  (tx_data_v[g]),
            .busy     (busy_v[g]),
            .done     (done_v[g])
        );
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int busy_len = 10;

    bit         m_active     [NI];
    bit         m_drop       [NI];
    int         m_idx        [NI];
    int         m_next_start [NI];
    int         m_done_at    [NI];
    int         m_busy_from  [NI];
    int         m_ub         [NI];
    logic [7:0] m_last       [NI];
    logic [7:0] m_exp        [NI][NBYTES];
    logic [7:0] sent         [NI][64];
    int         start_cyc    [NI][64];
    int         nsent [NI];
    int         nstart[NI];
    int         ndone [NI];
    int         load_cyc;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp_v);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [W-1:0] r, input int msb, input int idx);
        int e = idx / BPE;
        int k = idx % BPE;
        logic [ELEM_W-1:0] el = ELEM_W'(r >> (ELEM_W * e));
        return (msb != 0) ? 8'(el >> (8 * (BPE - 1 - k))) : 8'(el >> (8 * k));
    endfunction

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v = '0;
        for (int e = 0; e < N_ELEM; e++) v[ELEM_W*e +: ELEM_W] = ELEM_W'($urandom_range(0, 65535));
        return v;
    endfunction

    function automatic logic [W-1:0] seq_vec();
        logic [W-1:0] v = '0;
        for (int e = 0; e < N_ELEM; e++) v[ELEM_W*e +: ELEM_W] = {8'(2*e + 1), 8'(2*e + 2)};
        return v;
    endfunction

    // One cycle of the reference: compare outputs, then let the uart model react.
    task automatic model_cycle(input int i);
        bit start_exp, done_exp, busy_exp;
        if (!rst) begin
            chk("rst_tx_start", 32'(tx_start_v[i]), 32'd0);
            chk("rst_tx_data",  32'(tx_data_v[i]),  32'd0);
            chk("rst_busy",     32'(busy_v[i]),     32'd0);
            chk("rst_done",     32'(done_v[i]),     32'd0);
            m_active[i] = 0; m_drop[i] = 0; m_ub[i] = 0; m_last[i] = 8'h00;
            m_next_start[i] = -1; m_done_at[i] = -1; tx_busy_v[i] = 1'b0;
            return;
        end
        start_exp = m_active[i] && (cyc == m_next_start[i]);
        done_exp  = m_active[i] && (cyc == m_done_at[i]);
        busy_exp  = m_active[i] && (cyc >= m_busy_from[i]) && (m_done_at[i] < 0 || cyc < m_done_at[i]);
        if (start_exp) m_last[i] = m_exp[i][m_idx[i]];
        chk("tx_start", 32'(tx_start_v[i]), 32'(start_exp));
        chk("tx_data",  32'(tx_data_v[i]),  32'(m_last[i]));
        chk("busy",     32'(busy_v[i]),     32'(busy_exp));
        chk("done",     32'(done_v[i]),     32'(done_exp));
        if (tx_start_v[i]) begin
            chk("start_while_tx_busy", 32'(tx_busy_v[i]), 32'd0);
            if (nstart[i] < 64) start_cyc[i][nstart[i]] = cyc;
            nstart[i]++;
        end
        if (done_v[i]) ndone[i]++;

        if (start_exp) begin
            if (m_drop[i]) begin
                m_drop[i] = 0;
                m_next_start[i] = cyc + ACK_TIMEOUT + 1;
            end else begin
                m_ub[i] = (busy_len > 0) ? busy_len : int'($urandom_range(1, 12));
                tx_busy_v[i] = 1'b1;
                if (nsent[i] < 64) sent[i][nsent[i]] = tx_data_v[i];
                nsent[i]++;
            end
        end else if (m_ub[i] > 0) begin
            m_ub[i]--;
            if (m_ub[i] == 0) begin
                tx_busy_v[i] = 1'b0;
                m_idx[i]++;
                if (m_idx[i] == NBYTES) m_done_at[i] = cyc + 1;
                else                    m_next_start[i] = cyc + 2;
            end
        end
        if (m_active[i] && cyc == m_done_at[i]) m_active[i] = 0;

        if (load && !m_active[i] && cyc != m_done_at[i]) begin
            m_active[i] = 1; m_idx[i] = 0; m_busy_from[i] = cyc + 1;
            m_next_start[i] = cyc + 2; m_done_at[i] = -1;
            nsent[i] = 0; nstart[i] = 0; ndone[i] = 0;
            load_cyc = cyc;
            for (int b = 0; b < NBYTES; b++) m_exp[i][b] = exp_byte(result, (i == 0) ? 1 : 0, b);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NI; i++) model_cycle(i);
        @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [W-1:0] r);
        load = 1'b1;
        result = r;
        step();
        load = 1'b0;
        result = rand_vec();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((m_active[0] || m_active[1]) && n < 3000) begin
            step();
            n++;
        end
        chk({name, "_frame_completes"}, 32'(m_active[0] || m_active[1]), 32'd0);
        repeat (2) step();
    endtask

    initial begin
        logic [W-1:0] v;
        int n;
        rst = 1'b0; load = 1'b0; result = '0;
        for (int i = 0; i < NI; i++) begin
            tx_busy_v[i] = 1'b0; m_drop[i] = 0; m_active[i] = 0;
            nsent[i] = 0; nstart[i] = 0; ndone[i] = 0;
        end
        repeat (3) step();
        rst = 1'b1;
        repeat (2) step();

        // Ascending pattern, fixed 10-cycle transmitter.
        send_frame(seq_vec());
        wait_idle("seq");
        chk("seq_b0",      32'(sent[0][0]),  32'h01);
        chk("seq_b1",      32'(sent[0][1]),  32'h02);
        chk("seq_b2",      32'(sent[0][2]),  32'h03);
        chk("seq_b17",     32'(sent[0][17]), 32'h12);
        chk("seq_starts",  32'(nstart[0]),   32'd18);
        chk("seq_dones",   32'(ndone[0]),    32'd1);
        chk("seq_lsb_b0",  32'(sent[1][0]),  32'h02);
        chk("seq_latency", 32'(start_cyc[0][0] - load_cyc), 32'd2);

        // Byte order.
        v = rand_vec();
        v[15:0] = 16'hA55A;
        send_frame(v);
        wait_idle("order");
        chk("order_lsb_b0", 32'(sent[1][0]), 32'h5A);
        chk("order_lsb_b1", 32'(sent[1][1]), 32'hA5);
        chk("order_msb_b0", 32'(sent[0][0]), 32'hA5);
        chk("order_msb_b1", 32'(sent[0][1]), 32'h5A);

        // Ignored start on the first byte (inst 0) and on a mid-frame byte (inst 1).
        m_drop[0] = 1;
        send_frame(seq_vec());
        repeat (40) step();
        m_drop[1] = 1;
        wait_idle("timeout");
        chk("to_starts",   32'(nstart[0]), 32'd19);
        chk("to_sent",     32'(nsent[0]),  32'd18);
        chk("to_b0",       32'(sent[0][0]), 32'h01);
        chk("to_b1",       32'(sent[0][1]), 32'h02);
        chk("to_retry_gap", 32'(start_cyc[0][1] - start_cyc[0][0]), 32'(ACK_TIMEOUT + 1));
        chk("to_lsb_starts", 32'(nstart[1]), 32'd19);

        // Second load mid-frame is ignored; load on the done cycle is ignored.
        send_frame(seq_vec());
        repeat (30) step();
        send_frame(rand_vec());
        n = 0;
        while (!(m_active[0] && m_done_at[0] == cyc + 1) && n < 3000) begin
            step();
            n++;
        end
        send_frame(rand_vec());
        repeat (3) step();
        chk("ovl_b5",     32'(sent[0][5]),  32'h06);
        chk("ovl_b17",    32'(sent[0][17]), 32'h12);
        chk("ovl_starts", 32'(nstart[0]),   32'd18);
        chk("ovl_dones",  32'(ndone[0]),    32'd1);
        chk("ovl_idle",   32'(busy_v[0]),   32'd0);

        // Reset while byte 5 is in flight, then restart from byte 0.
        send_frame(rand_vec());
        n = 0;
        while (!(m_idx[0] == 5 && m_ub[0] > 0) && n < 3000) begin
            step();
            n++;
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        repeat (2) step();
        v = rand_vec();
        v[15:0] = 16'hBEEF;
        send_frame(v);
        wait_idle("rst");
        chk("rst_restart_b0",     32'(sent[0][0]), 32'hBE);
        chk("rst_restart_lsb_b0", 32'(sent[1][0]), 32'hEF);
        chk("rst_restart_sent",   32'(nsent[0]),   32'd18);

        // Random frames with random transmitter busy lengths and dropped starts.
        busy_len = 0;
        for (int f = 0; f < 4; f++) begin
            m_drop[0] = 1'($urandom_range(0, 1));
            m_drop[1] = 1'($urandom_range(0, 1));
            send_frame(rand_vec());
            wait_idle("rand");
            chk("rand_sent0", 32'(nsent[0]), 32'd18);
            chk("rand_done1", 32'(ndone[1]), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
